// File: rtl/xif_copro_pkg.sv
// Shared coprocessor types: predecoder response, issue-buffer entry state and entry payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xif_copro_pkg;

    localparam int XIF_ID_WIDTH = 4;
    localparam int XIF_XLEN     = 32;
    localparam int XIF_NUM_RS   = 2;

    typedef logic [XIF_NUM_RS-1:0] use_gprs_t;

    // Predecoder response; the issue buffer reuses its use_gprs type.
    typedef struct packed {
        logic      accept;
        use_gprs_t use_gprs;
    } prd_rsp_t;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_KILL   = 2'd3
    } entry_state_e;

    typedef struct packed {
        logic [31:0]                             instr;
        logic [XIF_ID_WIDTH-1:0]                 id;
        logic [XIF_NUM_RS-1:0][XIF_XLEN-1:0]     rs;
        use_gprs_t                               use_gprs;
    } issue_entry_t;

endpackage

// File: rtl/xif_copro_issue_ptr.sv
// Queue pointer with an extra wrap bit; advances by one per cycle when inc_i is set.
// Latency: pointer updates on the clock edge after inc_i.
// Backpressure: none; the caller decides when to advance.
// Ports: clk_i/rst_i (sync active-high), inc_i advance request, ptr_o {wrap, index}.
module xif_copro_issue_ptr #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            r_ptr <= r_ptr + PW'(1);
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/xif_copro_issue_buffer.sv
// In-order XIF issue queue: holds entries until commit/kill, dispatches committed ones to EX.
// Latency: one cycle from commit to ex_valid_o; ex_* are combinational from the head entry.
// Backpressure: issue_ready_o drops when full (state only); ex_valid_o holds until ex_ready_i.
// Ports: issue_* from predecoder, commit_* from core, ex_* to execution unit,
//        occupancy_o live count, err_o one-cycle pulse on a bad commit.
// Optional: XIF_COPRO_ISSUE_STATS_EN adds stat_issued_o/stat_killed_o/stat_dispatched_o.
module xif_copro_issue_buffer
    import xif_copro_pkg::*;
#(
    parameter int DEPTH    = 4,
    // Payload widths are carried by issue_entry_t, so these must match the package.
    parameter int ID_WIDTH = XIF_ID_WIDTH,
    parameter int XLEN     = XIF_XLEN,
    parameter int NUM_RS   = XIF_NUM_RS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [31:0]               issue_instr_i,
    input  logic [ID_WIDTH-1:0]       issue_id_i,
    input  logic [NUM_RS*XLEN-1:0]    issue_rs_i,
    input  logic [NUM_RS-1:0]         issue_use_gprs_i,
    input  logic                      commit_valid_i,
    input  logic [ID_WIDTH-1:0]       commit_id_i,
    input  logic                      commit_kill_i,
    output logic                      ex_valid_o,
    input  logic                      ex_ready_i,
    output logic [31:0]               ex_instr_o,
    output logic [ID_WIDTH-1:0]       ex_id_o,
    output logic [NUM_RS*XLEN-1:0]    ex_rs_o,
    output logic [$clog2(DEPTH):0]    occupancy_o,
`ifdef XIF_COPRO_ISSUE_STATS_EN
    output logic [31:0]               stat_issued_o,
    output logic [31:0]               stat_killed_o,
    output logic [31:0]               stat_dispatched_o,
`endif
    output logic                      err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    entry_state_e  r_state [DEPTH];
    issue_entry_t  r_entry [DEPTH];
    logic          r_err;

    logic [PW-1:0] w_wr_ptr, w_cm_ptr, w_rd_ptr;
    logic [AW-1:0] w_wr_idx, w_cm_idx, w_rd_idx;
    logic [PW-1:0] w_occ;
    logic          w_issue, w_commit_ok, w_retire, w_dispatch, w_pend_exists;
    issue_entry_t  w_new, w_head;

    assign w_wr_idx = w_wr_ptr[AW-1:0];
    assign w_cm_idx = w_cm_ptr[AW-1:0];
    assign w_rd_idx = w_rd_ptr[AW-1:0];

    assign w_occ         = w_wr_ptr - w_rd_ptr;
    assign issue_ready_o = (w_occ != PW'(DEPTH));
    assign w_issue       = issue_valid_i & issue_ready_o;

    // Everything from cm_ptr up to wr_ptr is PEND; the entry being issued this
    // cycle sits at wr_ptr and so is never a commit target.
    assign w_pend_exists = (w_cm_ptr != w_wr_ptr) && (r_state[w_cm_idx] == ST_PEND);
    assign w_commit_ok   = commit_valid_i & w_pend_exists & (r_entry[w_cm_idx].id == commit_id_i);

    assign w_head     = r_entry[w_rd_idx];
    assign ex_valid_o = (r_state[w_rd_idx] == ST_COMMIT);
    assign w_dispatch = ex_valid_o & ex_ready_i;
    // Killed heads drain silently, one per cycle.
    assign w_retire   = w_dispatch | (r_state[w_rd_idx] == ST_KILL);

    xif_copro_issue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_issue),     .ptr_o(w_wr_ptr));
    xif_copro_issue_ptr #(.DEPTH(DEPTH)) u_cm_ptr (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_commit_ok), .ptr_o(w_cm_ptr));
    xif_copro_issue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_retire),    .ptr_o(w_rd_ptr));

    // Unused operands are zeroed on capture so the stored payload is already clean.
    always_comb begin
        w_new          = '0;
        w_new.instr    = issue_instr_i;
        w_new.id       = issue_id_i;
        w_new.use_gprs = issue_use_gprs_i;
        for (int k = 0; k < NUM_RS; k++) begin
            w_new.rs[k] = issue_use_gprs_i[k] ? issue_rs_i[k*XLEN +: XLEN] : '0;
        end
    end

    always_comb begin
        ex_rs_o = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            ex_rs_o[k*XLEN +: XLEN] = w_head.use_gprs[k] ? w_head.rs[k] : '0;
        end
    end

    assign ex_instr_o  = w_head.instr;
    assign ex_id_o     = w_head.id;
    assign occupancy_o = w_occ;
    assign err_o       = r_err;

    // Issue, commit and retire always hit distinct entries, so one chain suffices.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_state[i] <= ST_FREE;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue && (AW'(i) == w_wr_idx)) begin
                    r_state[i] <= ST_PEND;
                end else if (w_commit_ok && (AW'(i) == w_cm_idx)) begin
                    r_state[i] <= commit_kill_i ? ST_KILL : ST_COMMIT;
                end else if (w_retire && (AW'(i) == w_rd_idx)) begin
                    r_state[i] <= ST_FREE;
                end
            end
            r_err <= commit_valid_i & ~w_commit_ok;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_issue) r_entry[w_wr_idx] <= w_new;
    end

`ifdef XIF_COPRO_ISSUE_STATS_EN
    logic [31:0] r_stat_issued, r_stat_killed, r_stat_dispatched;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_issued     <= '0;
            r_stat_killed     <= '0;
            r_stat_dispatched <= '0;
        end else begin
            if (w_issue && (r_stat_issued != '1))
                r_stat_issued <= r_stat_issued + 32'd1;
            if (w_commit_ok && commit_kill_i && (r_stat_killed != '1))
                r_stat_killed <= r_stat_killed + 32'd1;
            if (w_dispatch && (r_stat_dispatched != '1))
                r_stat_dispatched <= r_stat_dispatched + 32'd1;
        end
    end

    assign stat_issued_o     = r_stat_issued;
    assign stat_killed_o     = r_stat_killed;
    assign stat_dispatched_o = r_stat_dispatched;
`endif

endmodule

// File: tb/tb_xif_copro_issue_buffer.sv
// Self-checking bench for xif_copro_issue_buffer: directed scenarios then random traffic.
// Latency: reference model predicts outputs every cycle from a queue of issued entries.
// Backpressure: ex_ready_i is driven low in directed and random phases.
module tb_xif_copro_issue_buffer;

    localparam int DEPTH = 4;
    localparam int PEND = 0, COMMITTED = 1, KILLED = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [63:0] issue_rs_i;
    logic [1:0]  issue_use_gprs_i;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_instr_o;
    logic [3:0]  ex_id_o;
    logic [63:0] ex_rs_o;
    logic [2:0]  occupancy_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    xif_copro_issue_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs_i(issue_rs_i), .issue_use_gprs_i(issue_use_gprs_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_instr_o(ex_instr_o), .ex_id_o(ex_id_o), .ex_rs_o(ex_rs_o),
        .occupancy_o(occupancy_o), .err_o(err_o)
    );

    // Reference model: a plain in-order list of live instructions.
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  id;
        logic [63:0] rs;
        int          st;
    } ment_t;

    ment_t q[$];
    logic  m_err;
    int    total = 0;
    int    bad   = 0;
    int    n_dispatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oldest_pend();
        for (int i = 0; i < q.size(); i++) if (q[i].st == PEND) return i;
        return -1;
    endfunction

    // Compare current outputs, advance the model with the current inputs, clock once.
    task automatic cycle();
        logic exp_valid;
        int   p;
        logic ok, do_issue, do_retire;
        ment_t e;
        exp_valid = (q.size() > 0) && (q[0].st == COMMITTED);
        chk("issue_ready", {63'd0, issue_ready_o}, {63'd0, q.size() < DEPTH});
        chk("ex_valid",    {63'd0, ex_valid_o},    {63'd0, exp_valid});
        chk("occupancy",   {61'd0, occupancy_o},   64'(q.size()));
        chk("err",         {63'd0, err_o},         {63'd0, m_err});
        if (exp_valid) begin
            chk("ex_instr", {32'd0, ex_instr_o}, {32'd0, q[0].instr});
            chk("ex_id",    {60'd0, ex_id_o},    {60'd0, q[0].id});
            chk("ex_rs",    ex_rs_o,             q[0].rs);
        end
        if (rst_i) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            do_issue  = issue_valid_i && (q.size() < DEPTH);
            p         = oldest_pend();
            ok        = commit_valid_i && (p >= 0) && (q[p].id == commit_id_i);
            do_retire = (q.size() > 0) &&
                        ((q[0].st == KILLED) || (q[0].st == COMMITTED && ex_ready_i));
            m_err     = commit_valid_i && !ok;
            if (ok) begin
                e = q[p];
                e.st = commit_kill_i ? KILLED : COMMITTED;
                q[p] = e;
            end
            if (do_retire) begin
                if (q[0].st == COMMITTED) n_dispatched++;
                void'(q.pop_front());
            end
            if (do_issue) begin
                e.instr = issue_instr_i;
                e.id    = issue_id_i;
                e.rs[31:0]  = issue_use_gprs_i[0] ? issue_rs_i[31:0]  : 32'd0;
                e.rs[63:32] = issue_use_gprs_i[1] ? issue_rs_i[63:32] : 32'd0;
                e.st    = PEND;
                q.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic set_issue(input logic [3:0] id, input logic [31:0] instr,
                             input logic [63:0] rs, input logic [1:0] use_g);
        issue_valid_i    = 1'b1;
        issue_id_i       = id;
        issue_instr_i    = instr;
        issue_rs_i       = rs;
        issue_use_gprs_i = use_g;
    endtask

    task automatic set_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    initial begin
        int d0;
        m_err = 1'b0;
        rst_i = 1'b1; ex_ready_i = 1'b1;
        issue_instr_i = '0; issue_id_i = '0; issue_rs_i = '0; issue_use_gprs_i = '0;
        commit_id_i = '0;
        idle();
        @(posedge clk_i); #1;
        cycle();
        rst_i = 1'b0;
        chk("reset_ready", {63'd0, issue_ready_o}, 64'd1);
        chk("reset_occ",   {61'd0, occupancy_o},   64'd0);
        chk("reset_valid", {63'd0, ex_valid_o},    64'd0);
        cycle();

        // Single instruction: rs1 unused must come out as zero.
        set_issue(4'd3, 32'h0400702B, {32'hDEADBEEF, 32'hF0000001}, 2'b01); cycle();
        idle(); set_commit(4'd3, 1'b0); cycle();
        idle();
        chk("t1_valid", {63'd0, ex_valid_o}, 64'd1);
        chk("t1_rs",    ex_rs_o,             {32'd0, 32'hF0000001});
        cycle(); cycle();

        // Kill at head: only ID 2 reaches EX.
        d0 = n_dispatched;
        set_issue(4'd1, 32'h11, 64'h1, 2'b11); cycle();
        set_issue(4'd2, 32'h22, 64'h2, 2'b11); cycle();
        idle(); set_commit(4'd1, 1'b1); cycle();
        idle(); set_commit(4'd2, 1'b0); cycle();
        idle(); cycle(); cycle(); cycle();
        chk("t2_occ",   {61'd0, occupancy_o}, 64'd0);
        chk("t2_count", 64'(n_dispatched - d0), 64'd1);

        // Full: 5th request held until a retirement frees a slot.
        for (int i = 0; i < 4; i++) begin
            set_issue(4'(8 + i), 32'h100 + i, {32'(i), 32'(i)}, 2'b10); cycle();
        end
        chk("t3_full", {63'd0, issue_ready_o}, 64'd0);
        set_issue(4'd12, 32'h1FF, 64'hC, 2'b01); cycle();
        set_commit(4'd8, 1'b0); cycle();
        commit_valid_i = 1'b0; cycle();
        chk("t3_ready_back", {63'd0, issue_ready_o}, 64'd1);
        cycle();
        idle();
        for (int i = 9; i <= 12; i++) begin set_commit(4'(i), 1'b0); cycle(); end
        idle(); cycle(); cycle();

        // Backpressure: payload holds while ex_ready_i is low.
        ex_ready_i = 1'b0;
        set_issue(4'd5, 32'h0400702B, {32'hA5A5A5A5, 32'h5A5A5A5A}, 2'b11); cycle();
        idle(); set_commit(4'd5, 1'b0); cycle();
        idle(); cycle(); cycle(); cycle();
        ex_ready_i = 1'b1; cycle();
        cycle();
        chk("t4_occ", {61'd0, occupancy_o}, 64'd0);

        // ID mismatch: error pulse, entry stays pending, then a good commit.
        set_issue(4'd6, 32'h66, 64'h6, 2'b01); cycle();
        idle(); set_commit(4'd7, 1'b0); cycle();
        idle();
        chk("t5_err", {63'd0, err_o}, 64'd1);
        cycle();
        chk("t5_err_clr", {63'd0, err_o}, 64'd0);
        set_commit(4'd6, 1'b0); cycle();
        idle(); cycle(); cycle();

        // Reset mid-operation.
        ex_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_issue(4'(i), 32'h300 + i, 64'(i), 2'b11); cycle();
        end
        idle(); set_commit(4'd1, 1'b0); cycle();
        idle(); cycle();
        rst_i = 1'b1; cycle();
        rst_i = 1'b0;
        chk("t6_valid", {63'd0, ex_valid_o},    64'd0);
        chk("t6_occ",   {61'd0, occupancy_o},   64'd0);
        chk("t6_ready", {63'd0, issue_ready_o}, 64'd1);
        ex_ready_i = 1'b1;
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int p;
            issue_valid_i    = ($urandom_range(0, 99) < 55);
            issue_id_i       = 4'($urandom);
            issue_instr_i    = $urandom;
            issue_rs_i       = {$urandom, $urandom};
            issue_use_gprs_i = 2'($urandom);
            p = oldest_pend();
            commit_valid_i   = ($urandom_range(0, 99) < 45);
            commit_kill_i    = ($urandom_range(0, 99) < 25);
            if (p >= 0 && $urandom_range(0, 99) < 85) commit_id_i = q[p].id;
            else                                      commit_id_i = 4'($urandom);
            ex_ready_i       = ($urandom_range(0, 99) < 60);
            rst_i            = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst_i = 1'b0;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
